// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and lane helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam int MMIO_REGION_BIT = 31;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_LO,
    LSU_HI,
    LSU_FIN,
    LSU_ERR
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Equivalent to the shifted size mask spilling into the next word.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off == 2'd3;
      default: return off != 2'd0;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_BYTE, F3_HALF, F3_WORD: return 1'b1;
      F3_LBU, F3_LHU:            return !we;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
interface load_store_unit_if #(
  parameter int CNT_WIDTH = 16
);
  import load_store_unit_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [ALEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 resp_err;
  logic                 mem_we;
  logic [3:0]           mem_be;
  logic [2:0]           mem_funct3;
  logic [ALEN-1:0]      mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [XLEN-1:0]      mem_rdata;
  logic [CNT_WIDTH-1:0] split_cnt;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_be, mem_funct3, mem_addr, mem_wdata, split_cnt
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_be, mem_funct3, mem_addr, mem_wdata, split_cnt
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Merges the two fetched words, shifts the addressed bytes down and extends them.
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] lo_word,
  input  logic [XLEN-1:0] hi_word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] word;

  assign word = XLEN'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (funct3)
      F3_BYTE: result = {{(XLEN-8){word[7]}}, word[7:0]};
      F3_HALF: result = {{(XLEN-16){word[15]}}, word[15:0]};
      F3_WORD: result = word;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, word[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned byte-enabled accesses,
// word-crossing accesses split into a LO and a HI word access.
//   state | meaning
//   IDLE  | ready for a request
//   LO    | first (or only) word access on the memory bus
//   HI    | second word of a split access; low load word captured
//   FIN   | last load word arrives; result aligned and registered
//   ERR   | rejected request; error response issued on exit
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int CNT_WIDTH        = 16
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  lsu_state_t           state_q, state_d;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [ALEN-1:0]      addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [XLEN-1:0]      lo_word_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [XLEN-1:0]      resp_rdata_q;
  logic [CNT_WIDTH-1:0] split_cnt_q;

  logic [1:0]          off;
  logic [7:0]          lane_mask;
  logic                split;
  logic [2*XLEN-1:0]   wdata_wide;
  logic [ALEN-1:0]     addr_word;
  logic                req_bad;
  logic                resp_fire;
  logic [XLEN-1:0]     align_lo, align_hi, load_result;

  assign off        = addr_q[1:0];
  assign lane_mask  = {4'b0000, size_mask(funct3_q[1:0])} << off;
  assign split      = |lane_mask[7:4];
  assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign addr_word  = {addr_q[ALEN-1:2], 2'b00};

  assign req_bad = !funct3_legal(bus.req_we, bus.req_funct3) ||
                   (crosses_word(bus.req_funct3[1:0], bus.req_addr[1:0]) &&
                    (!ALLOW_MISALIGNED || bus.req_addr[MMIO_REGION_BIT]));

  always_comb begin
    state_d   = state_q;
    resp_fire = 1'b0;
    case (state_q)
      LSU_IDLE: if (bus.req_valid) state_d = req_bad ? LSU_ERR : LSU_LO;
      LSU_LO: begin
        if (split) begin
          state_d = LSU_HI;
        end else if (we_q) begin
          state_d   = LSU_IDLE;
          resp_fire = 1'b1;
        end else begin
          state_d = LSU_FIN;
        end
      end
      LSU_HI: begin
        state_d   = we_q ? LSU_IDLE : LSU_FIN;
        resp_fire = we_q;
      end
      LSU_FIN, LSU_ERR: begin
        state_d   = LSU_IDLE;
        resp_fire = 1'b1;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = addr_word;
    bus.mem_wdata = '0;
    case (state_q)
      LSU_LO: begin
        bus.mem_we    = we_q;
        bus.mem_be    = lane_mask[3:0];
        bus.mem_wdata = wdata_wide[XLEN-1:0];
      end
      LSU_HI: begin
        bus.mem_we    = we_q;
        bus.mem_be    = lane_mask[7:4];
        bus.mem_addr  = addr_word + ALEN'(4);
        bus.mem_wdata = wdata_wide[2*XLEN-1:XLEN];
      end
      default: ;
    endcase
  end

  // Unsplit loads see their only word in FIN; split loads saved the low word in HI.
  assign align_lo = split ? lo_word_q : bus.mem_rdata;
  assign align_hi = split ? bus.mem_rdata : '0;

  load_store_unit_load_align u_align (
    .lo_word (align_lo),
    .hi_word (align_hi),
    .off     (off),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= F3_WORD;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_word_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      split_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_fire;
      if (state_q == LSU_IDLE && bus.req_valid) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (state_q == LSU_HI) lo_word_q <= bus.mem_rdata;
      if (resp_fire) begin
        resp_err_q   <= (state_q == LSU_ERR);
        resp_rdata_q <= (state_q == LSU_FIN) ? load_result : '0;
      end
      if (resp_fire && split && state_q != LSU_ERR && split_cnt_q != '1)
        split_cnt_q <= split_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.req_ready  = (state_q == LSU_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_funct3 = F3_WORD;
  assign bus.split_cnt  = split_cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a response scoreboard, plus
// back-to-back, mid-split reset and no-misalignment sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rd;
    logic        err;
    int          lat, nacc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_checks = 0, n_fail = 0, exp_cnt = 0, acc0_cnt = 0;
  exp_t sb[$];
  acc_t acc_q[$];
  vec_t vecs[19];
  logic [31:0] mem [0:1023] = '{default: 32'h0};

  load_store_unit_if #(.CNT_WIDTH(16)) bus ();
  load_store_unit_if #(.CNT_WIDTH(16)) bus0 ();

  load_store_unit #(.ALLOW_MISALIGNED(1'b1), .CNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-enabled memory with one-cycle read latency, plus an access log.
  always @(posedge clk) begin
    if (bus.mem_be != 4'b0000) begin
      acc_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata});
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= mem[bus.mem_addr[11:2]];
    if (bus0.mem_be != 4'b0000) acc0_cnt <= acc0_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", bus.resp_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rd);
        chk("resp_err", bus.resp_err, e.err);
        chk("resp_latency", cyc - e.t_acc, e.lat);
      end
    end
  end

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rd, logic err, int lat, int nacc,
                              logic [31:0] a0, logic [3:0] be0, logic [31:0] wd0,
                              logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.err = err;
    v.lat = lat; v.nacc = nacc; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d responses outstanding, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 1);
    acc_q.delete();
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    sb.push_back('{v.rd, v.err, v.lat, cyc});
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle(tag);
    if (v.nacc == 2) exp_cnt++;
    chk({tag, "_n_access"}, acc_q.size(), v.nacc);
    if (v.nacc >= 1 && acc_q.size() >= 1) begin
      chk({tag, "_addr0"}, acc_q[0].addr, v.a0);
      chk({tag, "_be0"}, acc_q[0].be, v.be0);
      chk({tag, "_we0"}, acc_q[0].we, v.we);
      if (v.we) chk({tag, "_wdata0"}, acc_q[0].wdata, v.wd0);
    end
    if (v.nacc == 2 && acc_q.size() >= 2) begin
      chk({tag, "_addr1"}, acc_q[1].addr, v.a1);
      chk({tag, "_be1"}, acc_q[1].be, v.be1);
      if (v.we) chk({tag, "_wdata1"}, acc_q[1].wdata, v.wd1);
    end
    chk({tag, "_split_cnt"}, bus.split_cnt, exp_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int t0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = F3_WORD;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = F3_WORD;
    bus0.req_addr = '0; bus0.req_wdata = '0; bus0.mem_rdata = '0;

    //            we f3       addr          wdata         rd            err lat n a0            be0      wd0           a1          be1      wd1
    vecs[0]  = mk(1, F3_WORD, 32'h100,      32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h100,      4'b1111, 32'hDEADBEEF, 0,          4'b0000, 0);
    vecs[1]  = mk(0, F3_WORD, 32'h100,      32'h0,        32'hDEADBEEF, 0, 3, 1, 32'h100,      4'b1111, 0,            0,          4'b0000, 0);
    vecs[2]  = mk(1, F3_BYTE, 32'h103,      32'h80,       32'h0,        0, 2, 1, 32'h100,      4'b1000, 32'h80000000, 0,          4'b0000, 0);
    vecs[3]  = mk(0, F3_BYTE, 32'h103,      32'h0,        32'hFFFFFF80, 0, 3, 1, 32'h100,      4'b1000, 0,            0,          4'b0000, 0);
    vecs[4]  = mk(0, F3_LBU,  32'h103,      32'h0,        32'h00000080, 0, 3, 1, 32'h100,      4'b1000, 0,            0,          4'b0000, 0);
    vecs[5]  = mk(1, F3_WORD, 32'h200,      32'h44332211, 32'h0,        0, 2, 1, 32'h200,      4'b1111, 32'h44332211, 0,          4'b0000, 0);
    vecs[6]  = mk(1, F3_WORD, 32'h204,      32'h88776655, 32'h0,        0, 2, 1, 32'h204,      4'b1111, 32'h88776655, 0,          4'b0000, 0);
    vecs[7]  = mk(0, F3_WORD, 32'h202,      32'h0,        32'h66554433, 0, 4, 2, 32'h200,      4'b1100, 0,            32'h204,    4'b0011, 0);
    vecs[8]  = mk(0, F3_HALF, 32'h201,      32'h0,        32'h00003322, 0, 3, 1, 32'h200,      4'b0110, 0,            0,          4'b0000, 0);
    vecs[9]  = mk(0, F3_LHU,  32'h206,      32'h0,        32'h00008877, 0, 3, 1, 32'h204,      4'b1100, 0,            0,          4'b0000, 0);
    vecs[10] = mk(0, F3_HALF, 32'h206,      32'h0,        32'hFFFF8877, 0, 3, 1, 32'h204,      4'b1100, 0,            0,          4'b0000, 0);
    vecs[11] = mk(1, F3_HALF, 32'h207,      32'hBEEF,     32'h0,        0, 3, 2, 32'h204,      4'b1000, 32'hEF000000, 32'h208,    4'b0001, 32'h000000BE);
    vecs[12] = mk(0, F3_LHU,  32'h207,      32'h0,        32'h0000BEEF, 0, 4, 2, 32'h204,      4'b1000, 0,            32'h208,    4'b0001, 0);
    vecs[13] = mk(0, F3_WORD, 32'h80000002, 32'h0,        32'h0,        1, 2, 0, 0,            4'b0000, 0,            0,          4'b0000, 0);
    vecs[14] = mk(0, 3'b011,  32'h100,      32'h0,        32'h0,        1, 2, 0, 0,            4'b0000, 0,            0,          4'b0000, 0);
    vecs[15] = mk(1, F3_LBU,  32'h100,      32'h55,       32'h0,        1, 2, 0, 0,            4'b0000, 0,            0,          4'b0000, 0);
    vecs[16] = mk(0, F3_BYTE, 32'h80000001, 32'h0,        32'h0,        0, 3, 1, 32'h80000000, 4'b0010, 0,            0,          4'b0000, 0);
    vecs[17] = mk(1, F3_WORD, 32'h1FF,      32'h11223344, 32'h0,        0, 3, 2, 32'h1FC,      4'b1000, 32'h44000000, 32'h200,    4'b0111, 32'h00112233);
    vecs[18] = mk(0, F3_WORD, 32'h1FF,      32'h0,        32'h11223344, 0, 4, 2, 32'h1FC,      4'b1000, 0,            32'h200,    4'b0111, 0);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_split_cnt", bus.split_cnt, 0);
    chk("rst_mem_funct3", bus.mem_funct3, F3_WORD);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Second request accepted in the cycle the first response is visible.
    @(negedge clk);
    acc_q.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_WORD;
    bus.req_addr = 32'h400; bus.req_wdata = 32'h11111111;
    sb.push_back('{32'h0, 1'b0, 2, cyc});
    @(negedge clk);
    chk("b2b_busy_ready", bus.req_ready, 0);
    bus.req_addr = 32'h404; bus.req_wdata = 32'h22222222;
    @(negedge clk);
    chk("b2b_resp_ready", bus.req_ready, 1);
    chk("b2b_resp_valid", bus.resp_valid, 1);
    sb.push_back('{32'h0, 1'b0, 2, cyc});
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle("b2b");
    run_vec(mk(0, F3_WORD, 32'h404, 0, 32'h22222222, 0, 3, 1, 32'h404, 4'b1111, 0, 0, 4'b0000, 0), "b2b_rd1");

    // Reset while the HI half of a split store is on the bus.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_WORD;
    bus.req_addr = 32'h301; bus.req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_mid_lo_be", bus.mem_be, 4'b1110);
    @(negedge clk);
    chk("rst_mid_hi_be", bus.mem_be, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("rst_mid_mem_we", bus.mem_we, 0);
    chk("rst_mid_mem_be", bus.mem_be, 0);
    chk("rst_mid_req_ready", bus.req_ready, 1);
    chk("rst_mid_resp_valid", bus.resp_valid, 0);
    chk("rst_mid_split_cnt", bus.split_cnt, 0);
    @(negedge clk);
    chk("rst_mid_resp_valid_late", bus.resp_valid, 0);
    run_vec(mk(0, F3_WORD, 32'h400, 0, 32'h11111111, 0, 3, 1, 32'h400, 4'b1111, 0, 0, 4'b0000, 0), "after_rst");

    // Unit built without misaligned support rejects LH 0x3 without touching memory.
    @(negedge clk);
    chk("nomis_ready", bus0.req_ready, 1);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_funct3 = F3_HALF; bus0.req_addr = 32'h3;
    t0 = cyc;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus0.resp_valid === 1'b1) begin
        got = 1'b1;
        chk("nomis_latency", cyc - t0, 2);
        chk("nomis_err", bus0.resp_err, 1);
        chk("nomis_rdata", bus0.resp_rdata, 0);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL nomis_timeout: no resp_valid, expected one");
    end
    chk("nomis_no_access", acc0_cnt, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
